// File: rtl/uart_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_dbg_pkg
//  Description : Shared state encodings and sizing helpers for the debug-UART
//                arbitration blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_dbg_pkg;

    // FSM encodings, kept 4 bits wide so they map directly onto o_state_debug
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_LOAD = 4'd1;
    localparam logic [3:0] ST_WAIT = 4'd2;

    // Ceiling log2, never below 1 so a 1-entry range still gets a real bit
    function automatic int clog2_f(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    // Number of UART bytes needed to carry one word
    function automatic int bytes_per_word(input int nb, input int data_bits);
        return nb / data_bits;
    endfunction

endpackage : uart_dbg_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Requester / UART-TX handshake bundle of the debug UART
//                arbiter. The master side is the requesters plus UART core,
//                the slave side is the arbiter itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NB        = 32,
    parameter int DATA_BITS = 8,
    parameter int N_REQ     = 3
);
    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*NB-1:0] i_req_data;
    logic                i_uart_tx_done;
    logic [N_REQ-1:0]    o_grant;
    logic [N_REQ-1:0]    o_done;
    logic                o_busy;
    logic [DATA_BITS-1:0] o_uart_tx_data;
    logic                o_uart_tx_ready;
    logic [3:0]          o_state_debug;

    modport master (
        output i_req, i_req_data, i_uart_tx_done,
        input  o_grant, o_done, o_busy, o_uart_tx_data, o_uart_tx_ready, o_state_debug
    );

    modport slave (
        input  i_req, i_req_data, i_uart_tx_done,
        output o_grant, o_done, o_busy, o_uart_tx_data, o_uart_tx_ready, o_state_debug
    );
endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit at or above the pointer, wrapping modulo N_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_dbg_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PW    = clog2_f(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [PW-1:0]    i_ptr,
    output logic      [PW-1:0]    o_idx,
    output logic                  o_valid
);

    // Scan candidates in priority order ptr, ptr+1, ... and keep the first hit
    always_comb begin
        int cand;
        o_idx   = '0;
        o_valid = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(i_ptr) + k) % N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!o_valid && (j == cand) && i_req[j]) begin
                    o_valid = 1'b1;
                    o_idx   = PW'(j);
                end
            end
        end
    end

endmodule : uart_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmitter among
//                N_REQ word producers. Latches the winner's word and sends
//                it MSB byte first over the UART start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_dbg_pkg::*;
#(
    parameter int NB        = 32,
    parameter int DATA_BITS = 8,
    parameter int N_REQ     = 3
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset,
    uart_tx_arbiter_if.slave  bus
);

    localparam int BYTES = bytes_per_word(NB, DATA_BITS);
    localparam int CW    = clog2_f(BYTES);
    localparam int PW    = clog2_f(N_REQ);

    logic [3:0]           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NB-1:0]        word_q, word_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_ready_q, tx_ready_d;

    logic [PW-1:0]        win_idx;
    logic                 win_valid;
    logic [NB-1:0]        win_word;
    logic [N_REQ-1:0]     win_oh;
    logic [N_REQ-1:0]     owner_oh;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .i_req   (bus.i_req),
        .i_ptr   (ptr_q),
        .o_idx   (win_idx),
        .o_valid (win_valid)
    );

    // Select the winner's word and build one-hot codes for winner and owner
    always_comb begin
        win_word = '0;
        win_oh   = '0;
        owner_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (PW'(j) == win_idx) begin
                win_word  = bus.i_req_data[j*NB +: NB];
                win_oh[j] = 1'b1;
            end
            owner_oh[j] = (PW'(j) == owner_q);
        end
    end

    // Next-state logic: arbitrate in IDLE, present a byte in LOAD, wait for done in WAIT
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        owner_d    = owner_q;
        grant_d    = '0;
        done_d     = '0;
        tx_data_d  = tx_data_q;
        tx_ready_d = tx_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    word_d  = win_word;
                    owner_d = win_idx;
                    grant_d = win_oh;
                    ptr_d   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d  = word_q[NB-1 -: DATA_BITS];
                tx_ready_d = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_uart_tx_done) begin
                    tx_ready_d = 1'b0;
                    word_d     = word_q << DATA_BITS;
                    if (cnt_q == CW'(BYTES - 1)) begin
                        cnt_d   = '0;
                        done_d  = owner_oh;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                // Unreachable encodings recover to a quiet IDLE
                tx_data_d  = '0;
                tx_ready_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            tx_data_q  <= '0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign bus.o_grant         = grant_q;
    assign bus.o_done          = done_q;
    assign bus.o_uart_tx_data  = tx_data_q;
    assign bus.o_uart_tx_ready = tx_ready_q;
    assign bus.o_busy          = (state_q != ST_IDLE);
    assign bus.o_state_debug   = state_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter: a vector table of
//                requests and expected grant owner / word, plus directed
//                sequences for spurious done, mid-word reset and early drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NB        = 32;
    localparam int DATA_BITS = 8;
    localparam int N_REQ     = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    uart_tx_arbiter_if #(.NB(NB), .DATA_BITS(DATA_BITS), .N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .NB        (NB),
        .DATA_BITS (DATA_BITS),
        .N_REQ     (N_REQ)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [2:0]  req;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        int          owner;
        logic [31:0] word;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_grant", 64'(bus.o_grant), 64'h0);
        chk("rst_done", 64'(bus.o_done), 64'h0);
        chk("rst_data", 64'(bus.o_uart_tx_data), 64'h0);
        chk("rst_ready", 64'(bus.o_uart_tx_ready), 64'h0);
        chk("rst_state", 64'(bus.o_state_debug), 64'h0);
        chk("rst_busy", 64'(bus.o_busy), 64'h0);
        rst_n = 1'b1;
    endtask

    task automatic set_inputs(input logic [2:0] req, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2);
        bus.i_req      = req;
        bus.i_req_data = {d2, d1, d0};
    endtask

    task automatic wait_grant(input int owner);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.o_grant == '0 && cyc < 10);
        chk("grant", 64'(bus.o_grant), 64'(3'b001 << owner));
        chk("grant_state", 64'(bus.o_state_debug), 64'h1);
        chk("grant_busy", 64'(bus.o_busy), 64'h1);
        chk("grant_nodone", 64'(bus.o_done), 64'h0);
    endtask

    // Answer each byte with a done pulse 5 cycles after ready rises
    task automatic serve_word(input logic [31:0] w, input int owner,
                              input int first, input int last);
        int cyc;
        logic [7:0] exp_byte;
        for (int b = first; b <= last; b++) begin
            cyc = 0;
            while (!bus.o_uart_tx_ready && cyc < 10) begin
                tick();
                cyc++;
            end
            exp_byte = w[31 - 8*b -: 8];
            chk("ready_rise", 64'(bus.o_uart_tx_ready), 64'h1);
            chk("byte", 64'(bus.o_uart_tx_data), 64'(exp_byte));
            chk("wait_state", 64'(bus.o_state_debug), 64'h2);
            repeat (4) tick();
            chk("ready_hold", 64'(bus.o_uart_tx_ready), 64'h1);
            chk("grant_quiet", 64'(bus.o_grant), 64'h0);
            bus.i_uart_tx_done = 1'b1;
            tick();
            bus.i_uart_tx_done = 1'b0;
            chk("ready_drop", 64'(bus.o_uart_tx_ready), 64'h0);
            if (b < 3) begin
                chk("mid_nodone", 64'(bus.o_done), 64'h0);
                chk("mid_state", 64'(bus.o_state_debug), 64'h1);
                if (b < last) begin
                    tick();
                    chk("ready_gap1", 64'(bus.o_uart_tx_ready), 64'h1);
                end
            end else begin
                chk("done", 64'(bus.o_done), 64'(3'b001 << owner));
                chk("end_state", 64'(bus.o_state_debug), 64'h0);
                chk("end_busy", 64'(bus.o_busy), 64'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.i_req          = '0;
        bus.i_req_data     = '0;
        bus.i_uart_tx_done = 1'b0;

        //           rst  req     d0            d1            d2            own word
        tbl[0]  = '{1'b1, 3'b001, 32'hDEADBEEF, 32'h0,        32'h0,        0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 0, 32'h11111111};
        tbl[2]  = '{1'b0, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 1, 32'h22222222};
        tbl[3]  = '{1'b0, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 2, 32'h33333333};
        tbl[4]  = '{1'b0, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 0, 32'h11111111};
        tbl[5]  = '{1'b0, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 1, 32'h22222222};
        tbl[6]  = '{1'b0, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 2, 32'h33333333};
        tbl[7]  = '{1'b1, 3'b101, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 0, 32'hA0A1A2A3};
        tbl[8]  = '{1'b0, 3'b101, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 2, 32'hC0C1C2C3};
        tbl[9]  = '{1'b0, 3'b101, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 0, 32'hA0A1A2A3};
        tbl[10] = '{1'b0, 3'b101, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 2, 32'hC0C1C2C3};

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) begin
                bus.i_req = '0;
                do_reset();
            end
            set_inputs(tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            wait_grant(tbl[i].owner);
            serve_word(tbl[i].word, tbl[i].owner, 0, 3);
        end
        bus.i_req = '0;
        tick();
        chk("idle_after_table", 64'(bus.o_state_debug), 64'h0);
        chk("done_one_cycle", 64'(bus.o_done), 64'h0);
        chk("data_held_idle", 64'(bus.o_uart_tx_data), 64'hC3);

        // Spurious done in IDLE and LOAD must not advance the word
        do_reset();
        set_inputs(3'b001, 32'h12345678, 32'h0, 32'h0);
        bus.i_uart_tx_done = 1'b1;
        tick();
        chk("sp_grant", 64'(bus.o_grant), 64'h1);
        chk("sp_load", 64'(bus.o_state_debug), 64'h1);
        bus.i_req = '0;
        tick();
        bus.i_uart_tx_done = 1'b0;
        chk("sp_ready", 64'(bus.o_uart_tx_ready), 64'h1);
        chk("sp_byte0", 64'(bus.o_uart_tx_data), 64'h12);
        repeat (3) tick();
        chk("sp_hold_state", 64'(bus.o_state_debug), 64'h2);
        chk("sp_hold_ready", 64'(bus.o_uart_tx_ready), 64'h1);
        chk("sp_hold_byte", 64'(bus.o_uart_tx_data), 64'h12);
        bus.i_uart_tx_done = 1'b1;
        tick();
        bus.i_uart_tx_done = 1'b0;
        chk("sp_drop", 64'(bus.o_uart_tx_ready), 64'h0);
        serve_word(32'h12345678, 0, 1, 3);

        // Reset after the second byte aborts the word; pointer returns to 0
        do_reset();
        set_inputs(3'b001, 32'hDEADBEEF, 32'h0, 32'h0);
        wait_grant(0);
        serve_word(32'hDEADBEEF, 0, 0, 1);
        rst_n = 1'b0;
        tick();
        chk("mr_ready", 64'(bus.o_uart_tx_ready), 64'h0);
        chk("mr_data", 64'(bus.o_uart_tx_data), 64'h0);
        chk("mr_state", 64'(bus.o_state_debug), 64'h0);
        chk("mr_done", 64'(bus.o_done), 64'h0);
        rst_n = 1'b1;
        set_inputs(3'b011, 32'hDEADBEEF, 32'h55555555, 32'h0);
        wait_grant(0);
        bus.i_req = '0;
        serve_word(32'hDEADBEEF, 0, 0, 3);

        // Requester drops request and data right after its grant
        do_reset();
        set_inputs(3'b010, 32'h0, 32'hCAFE0123, 32'h0);
        wait_grant(1);
        set_inputs(3'b000, 32'h0, 32'h0, 32'h0);
        serve_word(32'hCAFE0123, 1, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
